logicshifter_l2h_seq: RTL

//  Parametrised, sequenced successor of the 2-bit low-to-high logic shifter used in FET drivers.

---
 rtl/logicshifter_l2h_seq.sv | 92 +++++++++
 1 files changed

// File: rtl/logicshifter_l2h_seq.sv
// logicshifter_l2h_seq: sequenced low-to-high shifter front end with sync, glitch filter, settle and pair dead-time
module logicshifter_l2h_seq #(
  parameter int NCH           = 4,
  parameter int FILT_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int DEADTIME      = 3,
  parameter int PAIR_MODE     = 1
) (
  input  logic           CELCLK,
  input  logic           CELRST,
  input  logic           enable_logicshifter,
  input  logic [NCH-1:0] in,
  output logic [NCH-1:0] out,
  output logic           ready,
  output logic           fault
);
  localparam int FW = FILT_CYCLES > 0 ? $clog2(FILT_CYCLES + 1) : 1;
  localparam int DW = DEADTIME > 0 ? $clog2(DEADTIME + 1) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {OFF, SETTLE, ON} state_t;
  state_t state, state_nx;
  logic en_m, en_s, on_go, bad;
  logic [NCH-1:0] in_m, in_s, filt, gated, elig;
  logic [FW-1:0] fcnt [NCH];
  logic [DW-1:0] lc [NCH];
  logic [DW-1:0] lc_nx [NCH];
  logic [SW-1:0] scnt;
  // two-flop synchronisers for the asynchronous enable and requests
  always_ff @(posedge CELCLK) begin
    en_m <= CELRST ? 1'b0 : enable_logicshifter;
    en_s <= CELRST ? 1'b0 : en_m;
    in_m <= CELRST ? '0 : in;
    in_s <= CELRST ? '0 : in_m;
  end
  // per-channel filter: accept a new level only after it persists FILT_CYCLES+1 edges
  always_ff @(posedge CELCLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (CELRST || in_s[i] == filt[i]) begin
        fcnt[i] <= '0;
        if (CELRST) filt[i] <= 1'b0;
      end else if (fcnt[i] == FW'(FILT_CYCLES)) begin
        filt[i] <= in_s[i];
        fcnt[i] <= '0;
      end else fcnt[i] <= fcnt[i] + 1'b1;
    end
  end
  // low-time counters include the current edge, so a partner is eligible on the DEADTIME-th low edge
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      lc_nx[i] = out[i] ? '0 : (lc[i] >= DW'(DEADTIME) ? DW'(DEADTIME) : lc[i] + 1'b1);
      elig[i]  = lc_nx[i] >= DW'(DEADTIME);
    end
  end
  // saturating low-time counters, reset to satisfied so the first request is not delayed
  always_ff @(posedge CELCLK) begin
    for (int i = 0; i < NCH; i++) lc[i] <= CELRST ? DW'(DEADTIME) : lc_nx[i];
  end
  // request gating: break-before-make per pair, both-high requests drive neither side
  always_comb begin
    gated = filt;
    bad   = 1'b0;
    if (PAIR_MODE != 0)
      for (int k = 0; k < NCH / 2; k++) begin
        gated[2*k]   = filt[2*k] & ~filt[2*k+1] & elig[2*k+1];
        gated[2*k+1] = filt[2*k+1] & ~filt[2*k] & elig[2*k];
        bad          = bad | (filt[2*k] & filt[2*k+1]);
      end
  end
  // next state: losing enable always returns to OFF so a new enable re-runs SETTLE
  always_comb begin
    on_go    = state == ON && en_s;
    state_nx = !en_s ? OFF :
               state == OFF ? SETTLE :
               (state == SETTLE && scnt == SW'(SETTLE_CYCLES - 1)) ? ON : state;
  end
  // sequencer with registered outputs
  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      state <= OFF;
      scnt  <= '0;
      out   <= '0;
      ready <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_nx;
      scnt  <= state == SETTLE ? scnt + 1'b1 : '0;
      out   <= on_go ? gated : '0;
      ready <= state_nx == ON;
      fault <= fault | (state == ON && bad);
    end
  end
endmodule
